delay_line: RTL and testbench
=============================

# delay_line

Parametrised per-channel variable delay line for sample streams. It supersedes the fixed 64-bit, 16-tap shift-register delay. Channel count, channel width and maximum depth are set by parameters, and the stream input and output carry a valid strobe. Samples held before enough history exists are zero-masked. The block sits between ADC/DSP stream stages where per-channel alignment is needed; there is no backpressure.

## Interface
- CHANNELS, 4, number of independent channels
- CHAN_WIDTH, 16, bits per channel sample
- ADDR_WIDTH, 5, buffer address bits; depth 2^ADDR_WIDTH, maximum delay 2^ADDR_WIDTH-1
- aclk  input  1  clock; all logic on rising edge
- areset  input  1  synchronous, active-high reset
- cfg  input  CHANNELS*ADDR_WIDTH  per-channel delay in samples; channel c uses cfg[c*ADDR_WIDTH +: ADDR_WIDTH]
- s_axis_tdata  input  CHANNELS*CHAN_WIDTH  input samples; channel c uses bits [c*CHAN_WIDTH +: CHAN_WIDTH]
- s_axis_tvalid  input  1  input sample strobe; every valid cycle accepts one sample (no tready)
- m_axis_tdata  output  CHANNELS*CHAN_WIDTH  delayed samples; same channel packing as input
- m_axis_tvalid  output  1  output sample strobe

## Operation
- One clock, aclk. Reset is synchronous and active-high on areset.
- Shared circular buffer: 2^ADDR_WIDTH words, each CHANNELS*CHAN_WIDTH wide, with a write pointer wptr of ADDR_WIDTH bits. Distributed RAM is acceptable. The buffer contents are not reset.
- Accepted sample: a cycle with s_axis_tvalid=1 and areset=0.
  - Write mem[wptr] <= s_axis_tdata.
  - wptr <= wptr+1, wrapping modulo 2^ADDR_WIDTH.
- fill counter: ADDR_WIDTH bits, counts accepted samples since reset, saturates at 2^ADDR_WIDTH-1.
- cfg_r: registered copy of cfg, loaded every cycle with no qualification.
- Output for the accepted sample with index k (0 = first after reset), channel c, with d = cfg_r channel c:
  - d == 0: output the current input sample (bypass, no buffer read).
  - d > 0 and fill >= d: output mem[wptr-d] channel c, i.e. input sample k-d. Address arithmetic is modulo 2^ADDR_WIDTH.
  - d > 0 and fill < d: output 0 for that channel (history not yet available).
- Each channel selects its delay independently from the shared history. A cfg change takes effect immediately, with no flush and no zero gap, as long as fill >= the new d.
- Idle cycles (s_axis_tvalid=0):
  - wptr and fill hold.
  - m_axis_tdata holds its last value.
  - m_axis_tvalid=0.
- Delay is counted in accepted samples, not clock cycles.

## Timing
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, wptr=0, fill=0, cfg_r=0.
- Reset mid-stream clears wptr and fill. After reset every channel with d>0 outputs zeros again for its first d samples, and stale buffer contents are never emitted.
- Latency: the sample accepted at cycle t appears on m_axis_tdata at cycle t+1, with m_axis_tvalid=1 at t+1.
- cfg sampled at edge t is used for samples accepted from cycle t+1 onward. The cfg-to-effect latency is therefore 1 cycle.
- A same-cycle write and read at the same address cannot occur: d ranges 1..2^ADDR_WIDTH-1, so the read address differs from wptr. d=0 uses the bypass.
- Wrap-around: after 2^ADDR_WIDTH accepted samples, wptr returns to 0 and the oldest entry is overwritten. With d=2^ADDR_WIDTH-1 the output is still correct.
- Output register only: there is no combinational path from the s_axis ports to the m_axis ports.

## Test plan
- Reset and fill masking: defaults, cfg = 3 on all channels, input ramp 1,2,3,… on every valid cycle.
  - Required: outputs 0,0,0,1,2,3,…, each one cycle after its input.
  - Required: m_axis_tvalid=0 during reset.
- Independent channels: cfg channel0=0, channel1=1, channel2=5, channel3=31, ramp input.
  - Required: each channel lags by its own d.
  - Required: channel3 stays 0 for 31 samples, then outputs 1, and keeps tracking correctly across wptr wrap (at least 100 samples).
- Gapped valid: ramp input with s_axis_tvalid toggling 1,0,0,1,…, cfg=2.
  - Required: output values follow sample count, not cycles.
  - Required: m_axis_tdata holds during gaps; m_axis_tvalid mirrors the input strobe delayed by 1.
- Live cfg change: after 40 samples, switch cfg from 4 to 10.
  - Required: the next output (one sample later) equals input k-10, with no zeros (fill saturated).
  - Then switch 10→0: the output equals the current sample.
- Reset mid-stream: assert areset for 1 cycle after 50 samples with cfg=7.
  - Required: m_axis_tvalid and m_axis_tdata are 0 the next cycle.
  - Required: the first 7 post-reset outputs are 0, then the post-reset input sample 0 appears.

Source files
------------

// File: rtl/delay_line.sv
// Per-channel variable delay line over a shared circular sample history.
// Each channel taps the history at its own depth; taps beyond the accepted-sample count read as zero.
module delay_line #(
  parameter int CHANNELS   = 4,
  parameter int CHAN_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] cfg,
  input  logic [CHANNELS*CHAN_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic [CHANNELS*CHAN_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid
);

  localparam int DW    = CHANNELS * CHAN_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DW-1:0]                  mem [DEPTH];
  logic [ADDR_WIDTH-1:0]          wptr;
  logic [ADDR_WIDTH-1:0]          fill;
  logic [CHANNELS*ADDR_WIDTH-1:0] cfg_r;
  logic [DW-1:0]                  next_data;
  logic                           accept;

  assign accept = s_axis_tvalid & ~areset;

  // History storage is deliberately not reset; the fill count masks stale entries.
  always_ff @(posedge aclk) begin
    if (accept) begin
      mem[wptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wptr  <= '0;
      fill  <= '0;
      cfg_r <= '0;
    end else begin
      cfg_r <= cfg;
      if (accept) begin
        wptr <= wptr + 1'b1;
        if (fill != '1) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [ADDR_WIDTH-1:0] d;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [CHAN_WIDTH-1:0] rchan;

    assign d     = cfg_r[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign raddr = wptr - d;
    assign rchan = mem[raddr][c*CHAN_WIDTH +: CHAN_WIDTH];

    // d never exceeds DEPTH-1, so the read slot is always distinct from the write slot.
    assign next_data[c*CHAN_WIDTH +: CHAN_WIDTH] =
      (d == '0)    ? s_axis_tdata[c*CHAN_WIDTH +: CHAN_WIDTH] :
      (fill >= d)  ? rchan : '0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      m_axis_tvalid <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        m_axis_tdata <= next_data;
      end
    end
  end

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line: directed scenarios plus a randomized run,
// checked against a sample-history reference model.
module tb_delay_line;

  localparam int CH = 4;
  localparam int CW = 16;
  localparam int AW = 5;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [CH*AW-1:0]  cfg = '0;
  logic [CH*CW-1:0]  s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic [CH*CW-1:0]  m_axis_tdata;
  logic              m_axis_tvalid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: every sample accepted since reset, the delay in force,
  // and the expected registered outputs.
  logic [CH*CW-1:0] hist[$];
  logic [CH*AW-1:0] cfg_eff = '0;
  logic [CH*CW-1:0] exp_data = '0;
  logic             exp_valid = 1'b0;

  delay_line #(.CHANNELS(CH), .CHAN_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk),
    .areset(areset),
    .cfg(cfg),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid)
  );

  always #5 aclk = ~aclk;

  function automatic logic [CH*AW-1:0] all_cfg(input int d);
    logic [CH*AW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*AW +: AW] = AW'(d);
    return r;
  endfunction

  function automatic logic [CH*AW-1:0] cfg4(input int d0, input int d1, input int d2, input int d3);
    return {AW'(d3), AW'(d2), AW'(d1), AW'(d0)};
  endfunction

  // Channel c carries n + c*0x1000 so that channel crosstalk is visible.
  function automatic logic [CH*CW-1:0] ramp(input int n);
    logic [CH*CW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*CW +: CW] = CW'(n + c * 'h1000);
    return r;
  endfunction

  // Apply inputs for one clock, advance the model, then return 1 time unit after the edge.
  task automatic step(input logic rst, input logic vld, input logic [CH*CW-1:0] data,
                      input logic [CH*AW-1:0] c);
    int k;
    int d;
    logic [CH*CW-1:0] src;
    areset = rst;
    s_axis_tvalid = vld;
    s_axis_tdata = data;
    cfg = c;
    if (rst) begin
      exp_data = '0;
      exp_valid = 1'b0;
      hist.delete();
    end else begin
      exp_valid = vld;
      if (vld) begin
        k = hist.size();
        for (int ch = 0; ch < CH; ch++) begin
          d = int'(cfg_eff[ch*AW +: AW]);
          if (d == 0) begin
            exp_data[ch*CW +: CW] = data[ch*CW +: CW];
          end else if (k >= d) begin
            src = hist[k-d];
            exp_data[ch*CW +: CW] = src[ch*CW +: CW];
          end else begin
            exp_data[ch*CW +: CW] = '0;
          end
        end
        hist.push_back(data);
      end
    end
    cfg_eff = rst ? '0 : c;
    @(posedge aclk);
    #1;
  endtask

  task automatic restart(input logic [CH*AW-1:0] c);
    step(1'b1, 1'b0, '0, c);
    step(1'b0, 1'b0, '0, c);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, ramp(100 + i), all_cfg(3));
      n_checks++;
      if (m_axis_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valid: got %b expected 0", m_axis_tvalid);
      end
      n_checks++;
      if (m_axis_tdata !== '0) begin
        n_fail++;
        $display("FAIL reset_data: got %h expected 0", m_axis_tdata);
      end
    end
    step(1'b0, 1'b0, '0, all_cfg(3));
  endtask

  task automatic test_fill_mask;
    logic [CH*CW-1:0] want;
    for (int n = 1; n <= 24; n++) begin
      step(1'b0, 1'b1, ramp(n), all_cfg(3));
      want = (n > 3) ? ramp(n - 3) : '0;
      n_checks++;
      if (m_axis_tdata !== want || m_axis_tdata !== exp_data) begin
        n_fail++;
        $display("FAIL fill_data n=%0d: got %h expected %h", n, m_axis_tdata, want);
      end
      n_checks++;
      if (m_axis_tvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_valid n=%0d: got %b expected 1", n, m_axis_tvalid);
      end
    end
  endtask

  task automatic test_independent;
    logic [CH*AW-1:0] c;
    c = cfg4(0, 1, 5, 31);
    restart(c);
    for (int n = 1; n <= 120; n++) begin
      step(1'b0, 1'b1, ramp(n), c);
      n_checks++;
      if (m_axis_tdata !== exp_data) begin
        n_fail++;
        $display("FAIL indep_data n=%0d: got %h expected %h", n, m_axis_tdata, exp_data);
      end
      if (n == 31 || n == 32) begin
        n_checks++;
        if (m_axis_tdata[3*CW +: CW] !== ((n == 31) ? CW'(0) : CW'(1 + 3 * 'h1000))) begin
          n_fail++;
          $display("FAIL indep_ch3_edge n=%0d: got %h", n, m_axis_tdata[3*CW +: CW]);
        end
      end
    end
  endtask

  task automatic test_gapped;
    int n;
    restart(all_cfg(2));
    n = 1;
    for (int i = 0; i < 36; i++) begin
      if (i % 3 == 0) begin
        step(1'b0, 1'b1, ramp(n), all_cfg(2));
        n++;
      end else begin
        step(1'b0, 1'b0, ramp(9999), all_cfg(2));
      end
      n_checks++;
      if (m_axis_tdata !== exp_data) begin
        n_fail++;
        $display("FAIL gap_data i=%0d: got %h expected %h", i, m_axis_tdata, exp_data);
      end
      n_checks++;
      if (m_axis_tvalid !== (i % 3 == 0)) begin
        n_fail++;
        $display("FAIL gap_valid i=%0d: got %b expected %b", i, m_axis_tvalid, (i % 3 == 0));
      end
    end
  endtask

  task automatic test_cfg_change;
    logic [CH*AW-1:0] c;
    restart(all_cfg(4));
    for (int n = 1; n <= 70; n++) begin
      c = (n < 40) ? all_cfg(4) : (n < 55) ? all_cfg(10) : all_cfg(0);
      step(1'b0, 1'b1, ramp(n), c);
      n_checks++;
      if (m_axis_tdata !== exp_data) begin
        n_fail++;
        $display("FAIL cfg_data n=%0d: got %h expected %h", n, m_axis_tdata, exp_data);
      end
      if (n == 41 || n == 56) begin
        n_checks++;
        if (m_axis_tdata !== ((n == 41) ? ramp(31) : ramp(56))) begin
          n_fail++;
          $display("FAIL cfg_switch n=%0d: got %h", n, m_axis_tdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    restart(all_cfg(7));
    for (int n = 1; n <= 50; n++) step(1'b0, 1'b1, ramp(n), all_cfg(7));
    step(1'b1, 1'b1, ramp(777), all_cfg(7));
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got %b/%h expected 0/0", m_axis_tvalid, m_axis_tdata);
    end
    step(1'b0, 1'b0, '0, all_cfg(7));
    for (int n = 0; n < 12; n++) begin
      step(1'b0, 1'b1, ramp(500 + n), all_cfg(7));
      n_checks++;
      if (m_axis_tdata !== ((n < 7) ? '0 : ramp(500 + n - 7)) || m_axis_tdata !== exp_data) begin
        n_fail++;
        $display("FAIL midreset_data n=%0d: got %h expected %h", n, m_axis_tdata, exp_data);
      end
    end
  endtask

  task automatic test_random;
    logic [CH*AW-1:0] c;
    logic rst;
    c = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) c = CH*AW'($urandom);
      rst = ($urandom_range(299) == 0);
      step(rst, ($urandom_range(3) != 0), {$urandom, $urandom}, c);
      n_checks++;
      if (m_axis_tdata !== exp_data || m_axis_tvalid !== exp_valid) begin
        n_fail++;
        $display("FAIL random i=%0d: got %b/%h expected %b/%h", i,
                 m_axis_tvalid, m_axis_tdata, exp_valid, exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_mask();
    test_independent();
    test_gapped();
    test_cfg_change();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
